// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs a scalar valid/ready element stream into zero-padded lane vectors
module stream_packer #(
    parameter int WIDTH_P = 8,
    parameter int LANES_P = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [WIDTH_P-1:0]                data_i,
    input  logic                              valid_i,
    input  logic                              last_i,
    output logic                              ready_o,
    output logic [LANES_P*WIDTH_P-1:0]        data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [$clog2(LANES_P+1)-1:0]      count_o,
    output logic                              last_o
);

    localparam int IDX_W = $clog2(LANES_P);
    localparam int CNT_W = $clog2(LANES_P + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES_P - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept;
    logic             pop;
    logic             close;

    assign valid_o = (state_q == HOLD);
    // A presented vector only blocks input while downstream refuses it.
    assign ready_o = !valid_o || ready_i;
    assign accept  = valid_i && ready_o;
    assign pop     = valid_o && ready_i;
    assign close   = accept && ((idx_q == LAST_IDX) || last_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_o  <= '0;
            count_o <= '0;
            last_o  <= 1'b0;
        end else begin
            if (accept) begin
                // Lane 0 of a fresh vector clears the rest, so short vectors pad with zeros.
                if (idx_q == '0) begin
                    data_o <= {{((LANES_P - 1) * WIDTH_P){1'b0}}, data_i};
                end else begin
                    for (int k = 1; k < LANES_P; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            data_o[k*WIDTH_P +: WIDTH_P] <= data_i;
                        end
                    end
                end
                idx_q <= close ? '0 : idx_q + 1'b1;
            end

            if (close) begin
                state_q <= HOLD;
                count_o <= CNT_W'(idx_q) + CNT_W'(1);
                last_o  <= last_i;
            end else if (pop) begin
                state_q <= FILL;
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - self-checking bench for stream_packer with a queue-based vector model
module tb_stream_packer;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int CW = $clog2(L + 1);
    localparam int N6 = 1000;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [W-1:0]     data_i;
    logic             valid_i;
    logic             last_i;
    logic             ready_o;
    logic [L*W-1:0]   data_o;
    logic             valid_o;
    logic             ready_i;
    logic [CW-1:0]    count_o;
    logic             last_o;

    always #5 clk = ~clk;

    stream_packer #(.WIDTH_P(W), .LANES_P(L)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .count_o (count_o),
        .last_o  (last_o)
    );

    typedef struct packed {
        logic [L*W-1:0] d;
        logic [CW-1:0]  c;
        logic           l;
    } vec_t;

    vec_t         exp_q[$];
    vec_t         nv;
    logic [W-1:0] part_q[$];
    logic [W-1:0] src_d[$];
    logic         src_l[$];
    logic [W-1:0] fifo_d[$];
    logic         fifo_l[$];
    logic [CW-1:0] log_c[$];
    logic         log_l[$];

    int n_pass  = 0;
    int n_total = 0;
    int n_acc   = 0;
    bit strm_chk = 1'b0;
    bit src_chk  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Model: every accepted element joins the open vector; a full or tile-ending vector is queued.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            part_q.delete();
        end else begin
            check("ready_rule", ready_o, !valid_o || ready_i);
            check("valid_o", valid_o, exp_q.size() != 0);
            if (valid_o && exp_q.size() != 0) begin
                check("data_o", data_o, exp_q[0].d);
                check("count_o", count_o, exp_q[0].c);
                check("last_o", last_o, exp_q[0].l);
            end
            if (strm_chk) check("stream_ready", ready_o, 1);
            if (valid_o && ready_i && exp_q.size() != 0) begin
                log_c.push_back(exp_q[0].c);
                log_l.push_back(exp_q[0].l);
                void'(exp_q.pop_front());
            end
            if (valid_i && ready_o) begin
                n_acc++;
                if (src_chk) begin
                    if (src_d.size() == 0) check("src_extra", 1, 0);
                    else begin
                        check("src_data", data_i, src_d.pop_front());
                        check("src_last", last_i, src_l.pop_front());
                    end
                end
                part_q.push_back(data_i);
                if (part_q.size() == L || last_i) begin
                    nv.d = '0;
                    for (int k = 0; k < part_q.size(); k++) nv.d[k*W +: W] = part_q[k];
                    nv.c = CW'(part_q.size());
                    nv.l = last_i;
                    exp_q.push_back(nv);
                    part_q.delete();
                end
            end
        end
    end

    task automatic xfer(input logic [W-1:0] d, input logic l);
        int t;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        t = 0;
        @(negedge clk);
        while (!ready_o && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!ready_o) check("xfer_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        last_i  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gen, cyc, acc0;
        bit  acc_prev;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_data", data_o, 0);
        check("rst_last", last_o, 0);
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Full vector
        ready_i = 1'b1;
        xfer(8'h11, 0); xfer(8'h22, 0); xfer(8'h33, 0); xfer(8'h44, 0);
        valid_i = 1'b0;
        check("t1_valid", valid_o, 1);
        check("t1_data", data_o, 32'h44332211);
        check("t1_count", count_o, 4);
        check("t1_last", last_o, 0);
        idle(1);
        check("t1_one_cycle", valid_o, 0);

        // Partial tiles
        xfer(8'hA1, 0); xfer(8'hA2, 1);
        valid_i = 1'b0;
        check("t2_data", data_o, 32'h0000A2A1);
        check("t2_count", count_o, 2);
        check("t2_last", last_o, 1);
        idle(1);
        xfer(8'h5C, 1);
        valid_i = 1'b0;
        check("t2b_data", data_o, 32'h0000005C);
        check("t2b_count", count_o, 1);
        check("t2b_last", last_o, 1);
        idle(1);

        // Backpressure then pop+accept in the same cycle
        ready_i = 1'b0;
        xfer(8'hB1, 0); xfer(8'hB2, 0); xfer(8'hB3, 0); xfer(8'hB4, 0);
        valid_i = 1'b0;
        repeat (5) begin
            check("t3_ready_low", ready_o, 0);
            check("t3_hold_data", data_o, 32'hB4B3B2B1);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h77;
        last_i  = 1'b0;
        #1;
        check("t3_ready_up", ready_o, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("t3_popped", valid_o, 0);
        check("t3_lane0", data_o, 32'h00000077);
        xfer(8'h78, 1);
        valid_i = 1'b0;
        check("t3_close_data", data_o, 32'h00007877);
        check("t3_close_count", count_o, 2);
        idle(1);

        // Streaming with a tile end on the 10th element
        log_c.delete();
        log_l.delete();
        strm_chk = 1'b1;
        for (int i = 1; i <= 12; i++) xfer(W'(i), i == 10);
        valid_i  = 1'b0;
        strm_chk = 1'b0;
        check("t4_nvec", log_c.size(), 3);
        if (log_c.size() == 3) begin
            check("t4_c0", log_c[0], 4);
            check("t4_c1", log_c[1], 4);
            check("t4_c2", log_c[2], 2);
            check("t4_l0", log_l[0], 0);
            check("t4_l1", log_l[1], 0);
            check("t4_l2", log_l[2], 1);
        end
        xfer(8'd13, 0);
        valid_i = 1'b0;
        check("t4_no_close", valid_o, 0);

        // Asynchronous reset mid-fill
        #2 rst_ni = 1'b0;
        #1;
        check("t5_valid", valid_o, 0);
        check("t5_data", data_o, 0);
        check("t5_count", count_o, 0);
        check("t5_last", last_o, 0);
        @(posedge clk);
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        xfer(8'h01, 0); xfer(8'h02, 0); xfer(8'h03, 0); xfer(8'h04, 0);
        valid_i = 1'b0;
        check("t5_data_after", data_o, 32'h04030201);
        check("t5_count_after", count_o, 4);
        idle(1);

        // FIFO-fed random traffic
        src_chk  = 1'b1;
        acc0     = n_acc;
        gen      = 0;
        cyc      = 0;
        acc_prev = 1'b0;
        forever begin
            if (acc_prev) begin
                void'(fifo_d.pop_front());
                void'(fifo_l.pop_front());
            end
            if (gen == N6 && fifo_d.size() == 0) break;
            if (cyc > 20000) begin
                check("t6_timeout", 0, 1);
                break;
            end
            if (gen < N6 && fifo_d.size() < 8 && $urandom_range(0, 2) != 0) begin
                fifo_d.push_back(W'($urandom));
                fifo_l.push_back((gen == N6 - 1) || ($urandom_range(0, 4) == 0));
                src_d.push_back(fifo_d[fifo_d.size()-1]);
                src_l.push_back(fifo_l[fifo_l.size()-1]);
                gen++;
            end
            valid_i = fifo_d.size() != 0;
            data_i  = (fifo_d.size() != 0) ? fifo_d[0] : '0;
            last_i  = (fifo_l.size() != 0) ? fifo_l[0] : 1'b0;
            ready_i = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc_prev = valid_i && ready_o;
            @(posedge clk);
            #1;
            cyc++;
        end
        ready_i = 1'b1;
        idle(4);
        src_chk = 1'b0;
        check("t6_accepted", n_acc - acc0, N6);
        check("t6_src_left", src_d.size(), 0);
        check("t6_vec_left", exp_q.size(), 0);
        check("t6_partial_left", part_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
